// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op codes, FSM states and result-mux select codes for the multiply/divide unit
package mdu_pkg;
    localparam logic [2:0] MDU_OP_MULT  = 3'd0;
    localparam logic [2:0] MDU_OP_MULTU = 3'd1;
    localparam logic [2:0] MDU_OP_DIV   = 3'd2;
    localparam logic [2:0] MDU_OP_DIVU  = 3'd3;
    localparam logic [1:0] OUT_SEL_HI   = 2'd2;
    localparam logic [1:0] OUT_SEL_LO   = 2'd3;
    typedef enum logic {MDU_IDLE, MDU_RUN} mdu_state_e;
endpackage

// File: rtl/md_compute.sv
// md_compute: combinational HI/LO result for mult/multu/div/divu plus the divide-by-zero keep flag
module md_compute
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        keep
);
    logic signed [63:0] sp;
    logic        [63:0] up;
    logic signed [31:0] sq, sr;
    logic        [31:0] uq, ur;
    // reserved op codes fall through to signed multiply
    always_comb begin
        sp   = $signed(a) * $signed(b);
        up   = {32'b0, a} * {32'b0, b};
        sq   = $signed(a) / $signed(b);
        sr   = $signed(a) % $signed(b);
        uq   = a / b;
        ur   = a % b;
        keep = (op == MDU_OP_DIV || op == MDU_OP_DIVU) && b == 32'b0;
        hi   = op == MDU_OP_MULTU ? up[63:32] : op == MDU_OP_DIV ? sr : op == MDU_OP_DIVU ? ur : sp[63:32];
        lo   = op == MDU_OP_MULTU ? up[31:0]  : op == MDU_OP_DIV ? sq : op == MDU_OP_DIVU ? uq : sp[31:0];
    end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: E-stage multiply/divide unit with fixed-latency emulation and architectural HI/LO
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        MDU_Start,
    input  logic [2:0]  MDU_Op,
    input  logic        MDU_HI_Write,
    input  logic        MDU_LO_Write,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int CW = $clog2(DIV_CYCLES + 1);
    mdu_state_e    state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [31:0]   res_hi, res_lo, pend_hi, pend_lo;
    logic          res_keep, pend_keep, is_div, load, commit, idle_wr;

    md_compute u_compute (
        .op   (MDU_Op),
        .a    (A),
        .b    (B),
        .hi   (res_hi),
        .lo   (res_lo),
        .keep (res_keep)
    );

    assign Start   = MDU_Start;
    assign is_div  = MDU_Op == MDU_OP_DIV || MDU_Op == MDU_OP_DIVU;
    assign idle_wr = state == MDU_IDLE && !MDU_Start;

    // next state: start loads the latency counter, the last RUN cycle commits
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        load    = 1'b0;
        commit  = 1'b0;
        if (state == MDU_IDLE) begin
            if (MDU_Start) begin
                state_d = MDU_RUN;
                cnt_d   = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                load    = 1'b1;
            end
        end else begin
            cnt_d = cnt - CW'(1);
            if (cnt == CW'(1)) begin
                state_d = MDU_IDLE;
                commit  = 1'b1;
            end
        end
    end

    // state, counter and registered Busy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= MDU_IDLE;
            cnt   <= '0;
            Busy  <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            Busy  <= state_d == MDU_RUN;
        end
    end

    // result held pending until commit; mthi/mtlo only act in IDLE without a start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_hi   <= '0;
            pend_lo   <= '0;
            pend_keep <= 1'b0;
            HI        <= '0;
            LO        <= '0;
        end else begin
            if (load) begin
                pend_hi   <= res_hi;
                pend_lo   <= res_lo;
                pend_keep <= res_keep;
            end
            if (commit && !pend_keep) begin
                HI <= pend_hi;
                LO <= pend_lo;
            end
            if (idle_wr && MDU_HI_Write) HI <= A;
            if (idle_wr && MDU_LO_Write) LO <= A;
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized self-checking bench against an arithmetic reference model
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        MDU_Start, MDU_HI_Write, MDU_LO_Write;
    logic [2:0]  MDU_Op;
    logic [31:0] A, B, HI, LO;
    logic        Start, Busy;
    logic [31:0] m_hi, m_lo;
    int          n_chk = 0, n_pass = 0;

    mult_div_unit dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .MDU_Start    (MDU_Start),
        .MDU_Op       (MDU_Op),
        .MDU_HI_Write (MDU_HI_Write),
        .MDU_LO_Write (MDU_LO_Write),
        .A            (A),
        .B            (B),
        .Start        (Start),
        .Busy         (Busy),
        .HI           (HI),
        .LO           (LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // model: apply op to architectural HI/LO using plain integer arithmetic
    task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == 3'd1) begin
            p = {32'b0, a} * {32'b0, b};
            {m_hi, m_lo} = p;
        end else if (op == 3'd2 || op == 3'd3) begin
            if (b != 0) begin
                if (op == 3'd2) begin
                    q = (sa < 0 ? -sa : sa) / (sb < 0 ? -sb : sb);
                    if ((sa < 0) != (sb < 0)) q = -q;
                    r = sa - q * sb;
                end else begin
                    q = longint'(a) / longint'(b);
                    r = longint'(a) - q * longint'(b);
                end
                m_lo = q[31:0];
                m_hi = r[31:0];
            end
        end else begin
            p = sa * sb;
            {m_hi, m_lo} = p;
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit wr, input bit junk);
        int n;
        n = (op == 3'd2 || op == 3'd3) ? 10 : 5;
        @(negedge clk);
        MDU_Start = 1'b1; MDU_Op = op; A = a; B = b;
        MDU_HI_Write = wr; MDU_LO_Write = wr;
        #1 check("start_comb", 64'(Start), 64'd1);
        @(negedge clk);
        MDU_Start = 1'b0; MDU_HI_Write = 1'b0; MDU_LO_Write = 1'b0;
        model_op(op, a, b);
        for (int i = 0; i < n; i++) begin
            check("busy_run", 64'(Busy), 64'd1);
            if (junk) begin
                MDU_Start = 1'b1; MDU_Op = 3'($urandom_range(0, 3));
                MDU_HI_Write = 1'b1; MDU_LO_Write = 1'b1;
                A = $urandom; B = $urandom;
            end
            @(negedge clk);
            MDU_Start = 1'b0; MDU_HI_Write = 1'b0; MDU_LO_Write = 1'b0;
        end
        check("busy_done", 64'(Busy), 64'd0);
        check("hilo", {HI, LO}, {m_hi, m_lo});
    endtask

    task automatic mt(input bit hw, input bit lw, input logic [31:0] a);
        @(negedge clk);
        MDU_HI_Write = hw; MDU_LO_Write = lw; A = a;
        @(negedge clk);
        MDU_HI_Write = 1'b0; MDU_LO_Write = 1'b0;
        if (hw) m_hi = a;
        if (lw) m_lo = a;
        check("mt_hilo", {HI, LO}, {m_hi, m_lo});
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [2:0]  rop;
        reset_n = 1'b0; MDU_Start = 1'b0; MDU_Op = 3'd0;
        MDU_HI_Write = 1'b0; MDU_LO_Write = 1'b0; A = '0; B = '0;
        m_hi = '0; m_lo = '0;
        #12;
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_hilo", {HI, LO}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 0, 0);
        check("mult_neg", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 0, 0);
        check("multu", {HI, LO}, 64'h0000_0001_FFFF_FFFE);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0, 0);
        check("div_neg", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 0, 0);
        check("divu", {HI, LO}, 64'h0000_0001_7FFF_FFFC);
        mt(1, 0, 32'd5);
        run_op(3'd2, 32'd100, 32'd0, 0, 0);
        check("div0_keep", {HI, LO}, 64'h0000_0005_7FFF_FFFC);
        run_op(3'd0, 32'd1234, 32'hFFFF_FF00, 0, 1);
        run_op(3'd5, 32'd7, 32'd9, 1, 0);
        check("reserved_mult", {HI, LO}, 64'd63);
        mt(1, 1, 32'hDEAD_BEEF);
        for (int k = 0; k < 25; k++) begin
            rop = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
            if ($urandom_range(0, 3) == 0) mt($urandom_range(0, 1) == 1, 1, $urandom);
            run_op(rop, ra, rb, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end
        @(negedge clk);
        MDU_Start = 1'b1; MDU_Op = 3'd2; A = 32'd77; B = 32'd5;
        @(negedge clk);
        MDU_Start = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        m_hi = '0; m_lo = '0;
        check("async_rst_busy", 64'(Busy), 64'd0);
        check("async_rst_hilo", {HI, LO}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        mt(0, 1, 32'd9);
        check("post_rst_lo", 64'(LO), 64'd9);
        repeat (12) @(negedge clk);
        check("post_rst_idle", {31'b0, Busy, HI}, 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
